// File: rtl/simon_round_ctrl.sv
// Round sequencer for the 3-button / 3-LED memory game: builds a pattern, shows it, then checks presses.
// Define SIMON_LFSR_EN to generate the pattern from an 8-bit LFSR instead of copying pat_in.
module simon_round_ctrl #(
    parameter int MAX_LEN     = 8,
    parameter int ON_CYC      = 200,
    parameter int GAP_CYC     = 50,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             len,
    input  logic [7:0]             seed,
    input  logic [2*MAX_LEN-1:0]   pat_in,
    input  logic [2:0]             btn,
    output logic [2:0]             led,
    output logic                   busy,
    output logic                   showing,
    output logic [3:0]             step,
    output logic                   win,
    output logic                   lose
);

    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH  = 2 ** AW;
    localparam int TMAX_A = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
    localparam int TW     = (TMAX > 3) ? $clog2(TMAX + 1) : 2;

    localparam logic [TW-1:0] T_ON  = TW'(ON_CYC);
    localparam logic [TW-1:0] T_GAP = TW'(GAP_CYC);
    localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT_CYC);
    localparam logic [AW-1:0] ADDR0 = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_GAP, S_WAIT_IN, S_ECHO, S_WIN, S_LOSE
    } state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [3:0]    len_q;
    logic [3:0]    len_c;
    logic [TW-1:0] timer;
    logic [2:0]    btn_q;
    logic [1:0]    pat_mem [DEPTH];
    logic [1:0]    gen_code;
    logic [AW-1:0] addr;
    logic [AW-1:0] nxt_addr;
    logic          last_idx;
    logic          press;
    logic          timer_done;
    logic [2:0]    cur_led;
    logic [2:0]    next_led;
    logic [2:0]    first_led;
    logic          unused_cfg_inputs;

    function automatic logic [2:0] code_led(input logic [1:0] code);
        case (code)
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    assign step       = idx;
    assign addr       = idx[AW-1:0];
    assign nxt_addr   = AW'(idx + 4'd1);
    assign last_idx   = (idx == len_q - 4'd1);
    assign press      = (btn != 3'b000) && (btn_q == 3'b000);
    assign timer_done = (timer < TW'(2));
    assign cur_led    = code_led(pat_mem[addr]);
    assign next_led   = code_led(pat_mem[nxt_addr]);
    // With len==1 entry 0 is still being written on the last GEN cycle, so bypass the store.
    assign first_led  = code_led((idx == 4'd0) ? gen_code : pat_mem[ADDR0]);

    // NOTE: every path assigns len_c, so this stays combinational and never infers a latch.
    always_comb begin
        if (len == 4'd0)
            len_c = 4'd1;
        else if (int'(len) > MAX_LEN)
            len_c = 4'(MAX_LEN);
        else
            len_c = len;
    end

`ifdef SIMON_LFSR_EN
    logic [7:0] lfsr;

    assign gen_code          = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
    assign unused_cfg_inputs = ^pat_in;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'h01;
        else if (state == S_IDLE && start)
            lfsr <= (seed == 8'h00) ? 8'h01 : seed;
        else if (state == S_GEN)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    assign gen_code          = pat_in[2*int'(addr) +: 2];
    assign unused_cfg_inputs = ^seed;
`endif

    // NOTE: the pattern store has no reset; every slot read in a round is written by GEN first.
    always_ff @(posedge clk) begin
        if (state == S_GEN)
            pat_mem[addr] <= gen_code;
    end

    // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            led     <= 3'b000;
            busy    <= 1'b0;
            showing <= 1'b0;
            idx     <= 4'd0;
            len_q   <= 4'd1;
            timer   <= '0;
            btn_q   <= 3'b111;
            win     <= 1'b0;
            lose    <= 1'b0;
        end else begin
            btn_q <= btn;
            win   <= 1'b0;
            lose  <= 1'b0;
            case (state)
                S_IDLE: begin
                    led <= 3'b000;
                    if (start) begin
                        state <= S_GEN;
                        busy  <= 1'b1;
                        idx   <= 4'd0;
                        len_q <= len_c;
                    end
                end
                S_GEN: begin
                    if (last_idx) begin
                        state   <= S_SHOW_ON;
                        idx     <= 4'd0;
                        led     <= first_led;
                        showing <= 1'b1;
                        timer   <= T_ON;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_SHOW_ON: begin
                    if (timer_done) begin
                        led <= 3'b000;
                        if (!last_idx) begin
                            state <= S_SHOW_GAP;
                            timer <= T_GAP;
                        end else begin
                            state   <= S_WAIT_IN;
                            idx     <= 4'd0;
                            showing <= 1'b0;
                            timer   <= T_TO;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_SHOW_GAP: begin
                    if (timer_done) begin
                        state <= S_SHOW_ON;
                        idx   <= idx + 4'd1;
                        led   <= next_led;
                        timer <= T_ON;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // A press wins over an expiring timeout in the same cycle.
                    if (press) begin
                        timer <= T_ON;
                        if (btn == cur_led) begin
                            state <= S_ECHO;
                            led   <= btn;
                        end else begin
                            state <= S_LOSE;
                            led   <= 3'b101;
                            lose  <= 1'b1;
                        end
                    end else if (TIMEOUT_CYC != 0) begin
                        if (timer == TW'(1)) begin
                            state <= S_LOSE;
                            led   <= 3'b101;
                            lose  <= 1'b1;
                            timer <= T_ON;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                S_ECHO: begin
                    if (timer_done) begin
                        if (last_idx) begin
                            state <= S_WIN;
                            led   <= 3'b111;
                            win   <= 1'b1;
                            timer <= T_ON;
                        end else begin
                            state <= S_WAIT_IN;
                            idx   <= idx + 4'd1;
                            led   <= 3'b000;
                            timer <= T_TO;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WIN, S_LOSE: begin
                    if (timer_done) begin
                        state <= S_IDLE;
                        led   <= 3'b000;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    led     <= 3'b000;
                    busy    <= 1'b0;
                    showing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: table-driven round traces plus hand-written corner sequences.
module tb_simon_round_ctrl;

    localparam int MAX_LEN = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [3:0]           len;
    logic [7:0]           seed;
    logic [2*MAX_LEN-1:0] pat_in;
    logic [2:0]           btn;
    logic [2:0]           led;
    logic                 busy;
    logic                 showing;
    logic [3:0]           step;
    logic                 win;
    logic                 lose;

    int n_cmp  = 0;
    int n_fail = 0;
    int now_c  = 0;

    typedef struct {
        int         at;
        logic [2:0] drv;
        logic [2:0] led;
        logic       busy;
        logic       showing;
        logic [3:0] step;
        logic       win;
        logic       lose;
    } vec_t;

    vec_t tab[$];

    simon_round_ctrl #(
        .MAX_LEN(MAX_LEN), .ON_CYC(200), .GAP_CYC(50), .TIMEOUT_CYC(2000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed), .pat_in(pat_in),
        .btn(btn), .led(led), .busy(busy), .showing(showing), .step(step),
        .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] outs();
        return {led, busy, showing, step, win, lose};
    endfunction

    function automatic logic [10:0] pack(input logic [2:0] l, input logic b, input logic s,
                                         input logic [3:0] st, input logic w, input logic lo);
        return {l, b, s, st, w, lo};
    endfunction

    function automatic vec_t mk(input int at, input logic [2:0] drv, input logic [2:0] l,
                                input logic b, input logic s, input logic [3:0] st,
                                input logic w, input logic lo);
        vec_t v;
        v.at = at; v.drv = drv; v.led = l; v.busy = b; v.showing = s;
        v.step = st; v.win = w; v.lose = lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got {led,busy,show,step,win,lose}=%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                     name, now_c, got[10:8], got[7], got[6], got[5:2], got[1], got[0],
                     exp[10:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Advance to cycle t of the current scenario; inputs change and outputs are sampled 1 ns after the edge.
    task automatic goto(input int t);
        while (now_c < t) begin
            @(posedge clk);
            #1;
            now_c++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; btn = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        now_c = 0;
        goto(2);
    endtask

    task automatic start_round(input logic [3:0] l, input logic [15:0] p, input logic [7:0] s);
        btn = 3'b000;
        now_c = 0;
        goto(2);
        len = l; pat_in = p; seed = s; start = 1'b1;
        now_c = 0;
        goto(1);
        start = 1'b0;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tab.size(); i++) begin
            goto(tab[i].at);
            check(name, outs(), pack(tab[i].led, tab[i].busy, tab[i].showing,
                                     tab[i].step, tab[i].win, tab[i].lose));
            btn = tab[i].drv;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 4'd0; seed = 8'h00; pat_in = '0; btn = 3'b000;
        do_reset();
        check("reset_state", outs(), pack(3'b000, 0, 0, 4'd0, 0, 0));

`ifdef SIMON_LFSR_EN
        // seed 01: codes 1 then 2 -> 010 then 100; seed 00 is promoted to 01.
        for (int k = 0; k < 2; k++) begin
            start_round(4'd2, 16'h0000, (k == 0) ? 8'h01 : 8'h00);
            goto(3);
            check("lfsr_show0", outs(), pack(3'b010, 1, 1, 4'd0, 0, 0));
            goto(253);
            check("lfsr_show1", outs(), pack(3'b100, 1, 1, 4'd1, 0, 0));
            do_reset();
        end
`else
        // Win: entries {2,0,1} -> shown 010,001,100; pressed b1,b0,b2.
        start_round(4'd3, {10'd0, 2'd2, 2'd0, 2'd1}, 8'h00);
        tab.delete();
        tab.push_back(mk(1,    3'b000, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(3,    3'b000, 3'b000, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(4,    3'b000, 3'b010, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(203,  3'b000, 3'b010, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(204,  3'b000, 3'b000, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(253,  3'b000, 3'b000, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(254,  3'b000, 3'b001, 1, 1, 4'd1, 0, 0));
        tab.push_back(mk(453,  3'b000, 3'b001, 1, 1, 4'd1, 0, 0));
        tab.push_back(mk(454,  3'b000, 3'b000, 1, 1, 4'd1, 0, 0));
        tab.push_back(mk(504,  3'b000, 3'b100, 1, 1, 4'd2, 0, 0));
        tab.push_back(mk(703,  3'b000, 3'b100, 1, 1, 4'd2, 0, 0));
        tab.push_back(mk(704,  3'b010, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(705,  3'b010, 3'b010, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(710,  3'b000, 3'b010, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(904,  3'b000, 3'b010, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(905,  3'b001, 3'b000, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(906,  3'b000, 3'b001, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(1105, 3'b000, 3'b001, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(1106, 3'b100, 3'b000, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(1107, 3'b000, 3'b100, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(1306, 3'b000, 3'b100, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(1307, 3'b000, 3'b111, 1, 0, 4'd2, 1, 0));
        tab.push_back(mk(1308, 3'b000, 3'b111, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(1506, 3'b000, 3'b111, 1, 0, 4'd2, 0, 0));
        tab.push_back(mk(1507, 3'b000, 3'b000, 0, 0, 4'd2, 0, 0));
        run_table("win_round");

        // Lose: b1 matches entry 0, b2 against entry 1 (expects b0) loses.
        start_round(4'd3, {10'd0, 2'd2, 2'd0, 2'd1}, 8'h00);
        tab.delete();
        tab.push_back(mk(704,  3'b010, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(710,  3'b000, 3'b010, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(905,  3'b100, 3'b000, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(906,  3'b000, 3'b101, 1, 0, 4'd1, 0, 1));
        tab.push_back(mk(907,  3'b000, 3'b101, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(1105, 3'b000, 3'b101, 1, 0, 4'd1, 0, 0));
        tab.push_back(mk(1106, 3'b000, 3'b000, 0, 0, 4'd1, 0, 0));
        run_table("lose_round");

        // Held button: b0 held from SHOW_ON into WAIT_IN is not a press; release and re-press is.
        // len=0 clamps to 1; entry 0 = code 0 -> 001.
        start_round(4'd0, 16'h0000, 8'h00);
        tab.delete();
        tab.push_back(mk(2,   3'b000, 3'b001, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(150, 3'b001, 3'b001, 1, 1, 4'd0, 0, 0));
        tab.push_back(mk(202, 3'b001, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(215, 3'b000, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(218, 3'b001, 3'b000, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(219, 3'b000, 3'b001, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(418, 3'b000, 3'b001, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(419, 3'b000, 3'b111, 1, 0, 4'd0, 1, 0));
        tab.push_back(mk(420, 3'b000, 3'b111, 1, 0, 4'd0, 0, 0));
        tab.push_back(mk(619, 3'b000, 3'b000, 0, 0, 4'd0, 0, 0));
        run_table("held_button");

        // Timeout: WAIT_IN entered at cycle 202, lose exactly 2000 cycles later.
        start_round(4'd1, 16'h0000, 8'h00);
        goto(202);
        check("timeout_entry", outs(), pack(3'b000, 1, 0, 4'd0, 0, 0));
        goto(2201);
        check("timeout_before", outs(), pack(3'b000, 1, 0, 4'd0, 0, 0));
        goto(2202);
        check("timeout_lose", outs(), pack(3'b101, 1, 0, 4'd0, 0, 1));
        goto(2203);
        check("timeout_pulse_end", outs(), pack(3'b101, 1, 0, 4'd0, 0, 0));
        goto(2402);
        check("timeout_idle", outs(), pack(3'b000, 0, 0, 4'd0, 0, 0));

        // Non-one-hot press is a mismatch.
        start_round(4'd1, 16'h0000, 8'h00);
        goto(202);
        btn = 3'b011;
        goto(203);
        check("multi_press_lose", outs(), pack(3'b101, 1, 0, 4'd0, 0, 1));
        btn = 3'b000;
        goto(403);
        check("multi_press_idle", outs(), pack(3'b000, 0, 0, 4'd0, 0, 0));

        // len=15 clamps to 8; start mid-round ignored; rst (with start) aborts to IDLE.
        start_round(4'd15, 16'hE4E4, 8'h00);
        goto(8);
        check("clamp_gen_last", outs(), pack(3'b000, 1, 0, 4'd7, 0, 0));
        goto(9);
        check("clamp_show0", outs(), pack(3'b001, 1, 1, 4'd0, 0, 0));
        goto(259);
        check("clamp_show1", outs(), pack(3'b010, 1, 1, 4'd1, 0, 0));
        start = 1'b1;
        goto(261);
        check("start_while_busy", outs(), pack(3'b010, 1, 1, 4'd1, 0, 0));
        rst = 1'b1;
        goto(262);
        check("rst_abort", outs(), pack(3'b000, 0, 0, 4'd0, 0, 0));
        rst = 1'b0; start = 1'b0;
        goto(264);
        check("rst_start_ignored", outs(), pack(3'b000, 0, 0, 4'd0, 0, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
